systolic_result_collector: RTL
==============================

Name: systolic_result_collector

Overview:
- Sits directly downstream of the eight_x_eight systolic array.
- Captures the diagonally skewed accumulator outputs c_out[8] and deskews them into an 8x8 result tile.
- Requantizes each result to DATA_WIDTH with optional ReLU, arithmetic right shift and saturation.
- Streams the tile out one row per beat over a valid/ready handshake to the next layer's operand buffer.

Parameters:
- DATA_WIDTH, 8: width of each requantized output element (signed).
- ACC_WIDTH, 32: width of each array accumulator result (signed).
- FIRST_LAT, 10: cycles from the start pulse to the first valid value (row 0) on c_in[0].

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse, asserted in the same cycle the array's enable first goes high.
- relu_en  input  1  clamp negative accumulators to 0 before shifting; sampled at start.
- shift  input  5  arithmetic right-shift amount, 0..31; sampled at start.
- c_in[8]  input  ACC_WIDTH each, signed  connected to the array's c_out[8].
- out_valid  output  1  out_row holds a valid row.
- out_ready  input  1  downstream accepts the row when high together with out_valid.
- out_row[8]  output  DATA_WIDTH each, signed  requantized row of C.
- out_row_idx  output  3  row index (0..7) of out_row.
- busy  output  1  high in CAPTURE and DRAIN.
- done  output  1  one-cycle pulse after row 7 is accepted.

Behaviour:
- Reset values: out_valid=0, out_row all 0, out_row_idx=0, busy=0, done=0, state=IDLE, cycle counter=0. Tile buffer contents are don't-care after reset.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The partial tile is discarded and no done is produced.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE on start. relu_en and shift are latched on that edge and the cycle counter t is cleared to 0. The start cycle itself is t=0.
- CAPTURE, per lane k (0..7): lane k carries row r of C in column k at t = FIRST_LAT + k + r, for r = 0..7.
  - On that cycle, c_in[k] is written into buffer[r][k], with r = t - FIRST_LAT - k.
  - Outside that window, lane k is ignored.
- CAPTURE -> DRAIN when t = FIRST_LAT + 14, i.e. after lane 7 writes row 7. That same cycle's write completes; out_valid rises on the next cycle.
- Requantization, applied combinationally to buffer[row_ptr] in DRAIN:
  - v = (relu && x<0) ? 0 : x
  - v = v >>> shift (arithmetic, floor toward -inf)
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- DRAIN: out_valid=1 with row_ptr starting at 0; out_row_idx = row_ptr.
  - out_row and out_row_idx are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, row_ptr increments; no bubble between rows.
- DRAIN -> IDLE on acceptance of row 7. In the following cycle: done=1, out_valid=0, busy=0.
- start in CAPTURE or DRAIN is ignored; start in the same cycle as done is accepted.
- shift >= ACC_WIDTH-1 yields 0 for non-negative and -1 for negative values (before saturation).
- out_ready held low indefinitely: the block stalls in DRAIN with no data loss.

Test Plan:
- Identity A times B = diag(1..8) (C[r][k]=(k+1)*(r==k)), shift=0, relu=0, out_ready=1: rows stream on consecutive cycles from t=FIRST_LAT+15. Row 3 = {0,0,0,4,0,0,0,0}. done at t=FIRST_LAT+23.
- Drive lane k with value 100*r+k at its skewed slot, shift=0: saturated rows match; row 0 = {0..7}, row 1 lane 0 = 100, row 2+ lanes = 127. Checks deskew indexing.
- Accumulators -1000 and 1000, shift=3: relu=0 gives -125 and 125; relu=1 gives 0 and 125. Accumulator -1 with shift=4, relu=0 gives -1 (floor).
- out_ready toggled 1,0,0,1,... during DRAIN: each row appears exactly once, in order 0..7, and is held stable while stalled.
- start pulsed again during CAPTURE: ignored, busy stays 1, only one done. Back-to-back start on the done cycle: second tile captured correctly.
- rst asserted at t=FIRST_LAT+5: next cycle IDLE, busy=0, out_valid=0. A fresh start then produces a correct full tile.

Source files
------------

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: deskews 8x8 systolic array outputs, requantizes them and streams the tile row by row
module systolic_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int FIRST_LAT  = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         relu_en,
    input  logic [4:0]                   shift,
    input  logic signed [ACC_WIDTH-1:0]  c_in [8],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_row [8],
    output logic [2:0]                   out_row_idx,
    output logic                         busy,
    output logic                         done
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [7:0] T_END = 8'(FIRST_LAT + 14);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t state, state_n;
    logic [7:0] t;
    logic [2:0] row_ptr;
    logic relu_q;
    logic [4:0] shift_q;
    logic accept, last;
    logic signed [ACC_WIDTH-1:0] tile [8][8];

    function automatic logic signed [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] x,
        input logic relu,
        input logic [4:0] sh
    );
        logic signed [ACC_WIDTH-1:0] v;
        v = (relu && x[ACC_WIDTH-1]) ? '0 : x;
        v = v >>> sh;
        return v > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0] : v < SAT_MIN ? SAT_MIN[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0];
    endfunction

    assign accept      = state == DRAIN && out_ready;
    assign last        = accept && row_ptr == 3'd7;
    assign busy        = state != IDLE;
    assign out_valid   = state == DRAIN;
    assign out_row_idx = row_ptr;

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // next state: start only honoured in IDLE, capture ends once lane 7 wrote row 7
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && start) ? CAPTURE :
                  (state == CAPTURE && t == T_END) ? DRAIN :
                  last ? IDLE : state;
    end

    // cycle counter, latched requant settings, drain row pointer and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            t       <= '0;
            row_ptr <= '0;
            relu_q  <= 1'b0;
            shift_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (state == IDLE && start) begin
                t       <= 8'd1;
                relu_q  <= relu_en;
                shift_q <= shift;
                row_ptr <= '0;
            end else if (state == CAPTURE) begin
                t <= t + 8'd1;
            end
            if (accept)
                row_ptr <= row_ptr + 3'd1;
        end
    end

    // deskew: lane k holds row r at t = FIRST_LAT + k + r
    always_ff @(posedge clk)
        for (int k = 0; k < 8; k++)
            if (state == CAPTURE && t >= 8'(FIRST_LAT + k) && t < 8'(FIRST_LAT + k + 8))
                tile[3'(t - 8'(FIRST_LAT + k))][k] <= c_in[k];

    // requantize the current drain row; zeros when not presenting data
    always_comb
        for (int k = 0; k < 8; k++)
            out_row[k] = state == DRAIN ? requant(tile[row_ptr][k], relu_q, shift_q) : '0;
endmodule
